// File: rtl/return_stack_pkg.sv
// return_stack_pkg: shared FSM encoding, fault codes and default sizing for the return stack
package return_stack_pkg;
  localparam int DEPTH_DEF = 8;
  localparam int AW_DEF = 10;
  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_ACTIVE = 2'd1,
    S_FULL   = 2'd2,
    S_FAULT  = 2'd3
  } state_t;
  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_OVF  = 2'b01;
  localparam logic [1:0] FC_UNF  = 2'b10;
  localparam logic [1:0] FC_BOTH = 2'b11;
endpackage

// File: rtl/return_stack_lifo_ram.sv
// lifo_ram: DEPTH x AW entry storage, one write port, asynchronous read
module lifo_ram #(
  parameter int DEPTH = 8,
  parameter int AW = 10
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [AW-1:0]            wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [AW-1:0]            rd_data
);
  logic [AW-1:0] mem [DEPTH];
  // entries are never cleared; occupancy tracking keeps stale data unreachable
  always_ff @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/return_stack.sv
// return_stack: subroutine return-address stack with overflow/underflow/conflict fault handling
module return_stack
  import return_stack_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                   CLK,
  input  logic                   RESET_n,
  input  logic                   HOLD,
  input  logic                   ir_strobe,
  input  logic                   bsr_det,
  input  logic                   ret_det,
  input  logic [AW-1:0]          ret_pc,
  input  logic                   err_clr,
  output logic [AW-1:0]          ret_addr,
  output logic                   ret_valid,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   empty,
  output logic                   full,
  output logic                   fault,
  output logic [1:0]             fault_code
);
  localparam int IW = $clog2(DEPTH);
  localparam int SW = IW + 1;
  state_t state, state_nx;
  logic ev, push, pop, both, do_push, do_pop, err, clr;
  logic [AW-1:0] rd_data;
  assign ev      = ir_strobe && !HOLD && state != S_FAULT;
  assign push    = ev && bsr_det && !ret_det;
  assign pop     = ev && ret_det && !bsr_det;
  assign both    = ev && bsr_det && ret_det;
  assign do_push = push && state != S_FULL;
  assign do_pop  = pop && state != S_EMPTY;
  assign err     = both || (push && state == S_FULL) || (pop && state == S_EMPTY);
  assign clr     = !HOLD && err_clr && state == S_FAULT;
  lifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk    (CLK),
    .wr_en  (do_push),
    .wr_addr(sp[IW-1:0]),
    .wr_data(ret_pc),
    .rd_addr(IW'(sp - SW'(1))),
    .rd_data(rd_data)
  );
  // state register
  always_ff @(posedge CLK)
    if (!RESET_n) state <= S_EMPTY;
    else state <= state_nx;
  // next state: faults win, then clear, then push/pop occupancy transitions
  always_comb
    state_nx = err     ? S_FAULT :
               clr     ? S_EMPTY :
               do_push ? (sp == SW'(DEPTH - 1) ? S_FULL : S_ACTIVE) :
               do_pop  ? (sp == SW'(1) ? S_EMPTY : S_ACTIVE) :
               state;
  // status flags decoded straight from registered state and occupancy
  always_comb begin
    empty = sp == '0;
    full  = sp == SW'(DEPTH);
    fault = state == S_FAULT;
  end
  // occupancy, popped address, one-cycle valid pulse and latched fault cause
  always_ff @(posedge CLK)
    if (!RESET_n) begin
      sp         <= '0;
      ret_addr   <= '0;
      ret_valid  <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      ret_valid <= do_pop;
      if (do_push) sp <= sp + SW'(1);
      if (do_pop) begin
        sp       <= sp - SW'(1);
        ret_addr <= rd_data;
      end
      if (err) fault_code <= both ? FC_BOTH : push ? FC_OVF : FC_UNF;
      if (clr) begin
        sp         <= '0;
        fault_code <= FC_NONE;
      end
    end
endmodule

// File: tb/tb_return_stack.sv
// tb_return_stack: scoreboard bench for return_stack against a queue-based stack model
module tb_return_stack;
  logic       CLK = 0, RESET_n = 0, HOLD = 0, ir_strobe = 0, bsr_det = 0, ret_det = 0, err_clr = 0;
  logic [9:0] ret_pc = 0, ret_addr;
  logic       ret_valid, empty, full, fault;
  logic [3:0] sp;
  logic [1:0] fault_code;
  int passes = 0, total = 0;
  logic [9:0] stk[$];
  logic [9:0] exp_q[$];
  bit   m_fault = 0, m_rv = 0;
  logic [1:0] m_fc = 0;
  logic [9:0] m_ra = 0;
  return_stack dut (
    .CLK(CLK), .RESET_n(RESET_n), .HOLD(HOLD), .ir_strobe(ir_strobe), .bsr_det(bsr_det),
    .ret_det(ret_det), .ret_pc(ret_pc), .err_clr(err_clr), .ret_addr(ret_addr),
    .ret_valid(ret_valid), .sp(sp), .empty(empty), .full(full), .fault(fault),
    .fault_code(fault_code)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // monitor: every ret_valid pulse must match the next expected popped address
  always @(negedge CLK)
    if (ret_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_ret_valid", 1, 0);
      else check("pop_addr", int'(ret_addr), int'(exp_q.pop_front()));
    end
  task automatic model(input bit rst, hold, strb, bsr, ret, clr, input logic [9:0] pc);
    m_rv = 0;
    if (rst) begin
      stk.delete(); m_fault = 0; m_fc = 0; m_ra = 0;
    end else if (!hold) begin
      if (m_fault) begin
        if (clr) begin stk.delete(); m_fault = 0; m_fc = 0; end
      end else if (strb) begin
        if (bsr && ret) begin m_fault = 1; m_fc = 2'b11; end
        else if (bsr) begin
          if (stk.size() == 8) begin m_fault = 1; m_fc = 2'b01; end
          else stk.push_back(pc);
        end else if (ret) begin
          if (stk.size() == 0) begin m_fault = 1; m_fc = 2'b10; end
          else begin m_ra = stk.pop_back(); m_rv = 1; exp_q.push_back(m_ra); end
        end
      end
    end
  endtask
  task automatic step(input bit rst, hold, strb, bsr, ret, clr, input logic [9:0] pc);
    RESET_n = !rst; HOLD = hold; ir_strobe = strb; bsr_det = bsr; ret_det = ret;
    err_clr = clr; ret_pc = pc;
    @(posedge CLK);
    #1 model(rst, hold, strb, bsr, ret, clr, pc);
    @(negedge CLK);
    check("sp", int'(sp), stk.size());
    check("empty", int'(empty), int'(stk.size() == 0));
    check("full", int'(full), int'(stk.size() == 8));
    check("fault", int'(fault), int'(m_fault));
    check("fault_code", int'(fault_code), int'(m_fc));
    check("ret_addr", int'(ret_addr), int'(m_ra));
    check("ret_valid", int'(ret_valid), int'(m_rv));
  endtask
  task automatic push(input logic [9:0] pc); step(0, 0, 1, 1, 0, 0, pc); endtask
  task automatic pop(); step(0, 0, 1, 0, 1, 0, 0); endtask
  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic clear(); step(0, 0, 0, 0, 0, 1, 0); endtask
  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 1, 10'h3ff);
    push(10'h012); push(10'h034); push(10'h056);
    pop(); pop(); pop(); idle();
    for (int i = 0; i < 9; i++) push(10'(i * 7 + 1));
    idle(); clear(); idle();
    pop(); push(10'h111); idle(); clear();
    push(10'h0aa); step(0, 0, 1, 1, 1, 0, 10'h0bb); idle(); clear();
    step(0, 0, 1, 1, 0, 0, 10'h2a5);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 10'h2a6);
    step(0, 1, 1, 1, 0, 0, 10'h2a7); step(0, 1, 1, 0, 1, 0, 0);
    pop(); pop(); clear();
    push(10'h101); push(10'h102); push(10'h103);
    step(1, 1, 0, 0, 0, 0, 0);
    pop(); clear();
    for (int i = 0; i < 3000; i++) begin
      automatic bit rst = $urandom_range(0, 99) == 0;
      automatic bit hold = $urandom_range(0, 7) == 0;
      automatic bit clr = $urandom_range(0, 11) == 0;
      automatic bit strb = $urandom_range(0, 1) == 1;
      automatic int k = $urandom_range(0, 19);
      step(rst, hold, strb, k < 10 || k == 19, k >= 10, clr, 10'($urandom));
    end
    idle(); idle();
    check("pending_pops", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 Parameter DEPTH, default 8, number of return-address entries (power of two, 2..16).
REQ-002 Parameter AW, default 10, return-address width (low field of a 22-bit instruction word).
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RESET_n  in  1  synchronous, active-low reset, sampled on rising CLK.
REQ-005 HOLD  in  1  high = freeze all state; strobes ignored that cycle.
REQ-006 ir_strobe  in  1  one-cycle pulse; bsr_det/ret_det valid for a newly loaded instruction.
REQ-007 bsr_det  in  1  current instruction is a subroutine call.
REQ-008 ret_det  in  1  current instruction is a return.
REQ-009 ret_pc  in  AW  return address to save on a call, valid with ir_strobe.
REQ-010 err_clr  in  1  one-cycle pulse; leave FAULT and empty the stack.
REQ-011 ret_addr  out  AW  popped return address, registered.
REQ-012 ret_valid  out  1  one-cycle pulse; ret_addr updated this cycle.
REQ-013 sp  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 empty / full  out  1 each  sp==0 / sp==DEPTH.
REQ-015 fault  out  1  high while in FAULT.
REQ-016 fault_code  out  2  01 overflow, 10 underflow, 11 simultaneous call+return, 00 none.

Function
REQ-017 Events act only when ir_strobe=1 and HOLD=0; bsr_det/ret_det levels without a strobe SHALL have no effect.
REQ-018 FSM states EMPTY, ACTIVE, FULL, FAULT; state encoding from the shared package.
REQ-019 Push (bsr_det=1, ret_det=0): write ret_pc to entry sp, sp+1 at the next edge; EMPTY->ACTIVE, or ACTIVE->FULL when the new sp==DEPTH.
REQ-020 Pop (ret_det=1, bsr_det=0): ret_addr<=entry sp-1, ret_valid=1 in the following cycle only, sp-1; FULL->ACTIVE, or ACTIVE->EMPTY when the new sp==0.
REQ-021 Pop latency: strobe at edge N -> ret_addr/ret_valid valid after edge N+1, one cycle.
REQ-022 Push in FULL: no write, sp unchanged, ->FAULT, fault_code=01.
REQ-023 Pop in EMPTY: ret_addr unchanged, ret_valid=0, ->FAULT, fault_code=10.
REQ-024 bsr_det and ret_det both 1 with strobe: no push/pop, ->FAULT, fault_code=11.
REQ-025 In FAULT: all strobes ignored, stack contents and sp frozen, fault=1.
REQ-026 err_clr in FAULT (HOLD=0): sp<=0, fault_code<=00, ->EMPTY next edge; err_clr outside FAULT ignored.
REQ-027 HOLD=1 freezes FSM, sp, entries, ret_addr; ret_valid forced 0 that cycle.
REQ-028 Storage is LIFO; push then pop SHALL return the last pushed value regardless of wrap of internal indices.
REQ-029 empty/full/fault decode combinationally from registered state/sp, no extra latency.

Reset
REQ-030 RESET_n=0 at a rising edge: state EMPTY, sp=0, ret_addr=0, ret_valid=0, fault_code=00; overrides HOLD, strobes, err_clr.
REQ-031 Entry storage need not be cleared by reset; an empty stack SHALL never expose stale data.
REQ-032 Reset asserted mid-sequence discards all saved addresses; first pop after release faults with 10.

Structure
REQ-033 Shared package holds FSM state encoding, fault_code constants, default DEPTH/AW.
REQ-034 One sub-module, lifo_ram (DEPTH x AW, single write port, async read), holds the entries; the top holds FSM, sp, flags.

Verification
REQ-035 Reset, then push 0x012, 0x034, 0x056, pop x3 -> ret_addr 0x056, 0x034, 0x012, each with one-cycle ret_valid, sp 3->0, empty=1.
REQ-036 Fill with DEPTH=8 pushes -> full=1, sp=8; ninth push -> fault=1, fault_code=01, sp stays 8; err_clr -> EMPTY, sp=0.
REQ-037 Pop from reset -> fault_code=10, ret_valid never asserted; subsequent push ignored until err_clr.
REQ-038 Strobe with bsr_det=ret_det=1 -> fault_code=11, sp unchanged.
REQ-039 bsr_det held high 5 cycles with one strobe -> exactly one push, sp=1; strobe with HOLD=1 -> no change.
REQ-040 Push 3, assert RESET_n=0 one cycle with HOLD=1 -> sp=0, EMPTY; next pop faults 10.
